// File: rtl/rv32i_types.sv
// Shared RV32I front-end types.
// Contents:
//   XLEN          architectural register/address width
//   PC_STEP       sequential fetch increment in bytes
//   fetch_entry_t one queued fetch result {pc, instr}
//   fetch_state_t fetch FSM states
package rv32i_types;

   localparam int XLEN    = 32;
   localparam int PC_STEP = 4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // IDLE: no read outstanding. FETCH: read outstanding, result kept.
   // SQUASH: read outstanding, result thrown away when it returns.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      SQUASH = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_queue_buffer.sv
// fetch_buffer: parametrised ring buffer of {pc, instr} pairs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear               drop all entries (pointers and count to 0)
//   enq, enq_pc/instr   push an entry at the tail
//   deq                 pop the head entry (ignored when empty)
//   head_pc/head_instr  head entry, read combinationally from storage
//   count, empty, full  occupancy
module fetch_buffer #(
   parameter  int width = 32,
   parameter  int depth = 8,
   localparam int PTR_W = $clog2(depth),
   localparam int CNT_W = $clog2(depth + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enq,
   input  logic [width-1:0] enq_pc,
   input  logic [width-1:0] enq_instr,
   input  logic             deq,
   output logic [width-1:0] head_pc,
   output logic [width-1:0] head_instr,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   logic [width-1:0] pc_mem    [depth];
   logic [width-1:0] instr_mem [depth];

   logic [PTR_W-1:0] head_reg, tail_reg;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             enq_fire, deq_fire;

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == CNT_W'(depth));
   assign deq_fire = deq & ~empty;
   // A push into a full ring is only safe when the head leaves on the same edge.
   assign enq_fire = enq & (~full | deq_fire);

   always_comb begin
      count_next = count_reg;
      case ({enq_fire, deq_fire})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // Pointers are exactly log2(depth) bits, so increment wraps modulo depth.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (enq_fire) tail_reg <= tail_reg + PTR_W'(1);
         if (deq_fire) head_reg <= head_reg + PTR_W'(1);
         count_reg <= count_next;
      end
   end

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (enq_fire && !clear && !rst) begin
         pc_mem[tail_reg]    <= enq_pc;
         instr_mem[tail_reg] <= enq_instr;
      end
   end

   assign head_pc    = pc_mem[head_reg];
   assign head_instr = instr_mem[head_reg];
   assign count      = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a decoupling queue.
// Issues one memory read at a time from fetch_pc, queues kept results and
// handles redirects by flushing the queue and squashing any in-flight read.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_mem_read/i_mem_address     read request (held until i_mem_resp)
//   i_mem_resp/i_mem_rdata       read completion and data
//   redirect/redirect_pc         flush and restart fetch at redirect_pc
//   deq                          consumer pops the head entry
//   out_valid/out_instr/out_pc   head entry
//   empty, full, count           queue occupancy
module fetch_queue
   import rv32i_types::*;
#(
   parameter  int               width    = 32,
   parameter  int               depth    = 8,
   parameter  logic [width-1:0] RESET_PC = width'(32'h0000_0060),
   localparam int               CNT_W    = $clog2(depth + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_mem_resp,
   input  logic [width-1:0] i_mem_rdata,
   output logic             i_mem_read,
   output logic [width-1:0] i_mem_address,
   input  logic             redirect,
   input  logic [width-1:0] redirect_pc,
   input  logic             deq,
   output logic             out_valid,
   output logic [width-1:0] out_instr,
   output logic [width-1:0] out_pc,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   fetch_state_t     state_reg, state_next;
   logic [width-1:0] fetch_pc_reg, fetch_pc_next;
   logic [width-1:0] squash_pc_reg, squash_pc_next;
   logic             enq;
   logic             deq_fire;

   assign deq_fire = deq & ~empty & ~redirect;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         fetch_pc_reg  <= RESET_PC;
         squash_pc_reg <= RESET_PC;
      end else begin
         state_reg     <= state_next;
         fetch_pc_reg  <= fetch_pc_next;
         squash_pc_reg <= squash_pc_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      fetch_pc_next  = fetch_pc_reg;
      squash_pc_next = squash_pc_reg;
      enq            = 1'b0;
      case (state_reg)
         IDLE: begin
            if (redirect) begin
               fetch_pc_next = redirect_pc;
            end else if (!full) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            if (redirect && i_mem_resp) begin
               // Read already finished: nothing left to squash.
               fetch_pc_next = redirect_pc;
               state_next    = IDLE;
            end else if (redirect) begin
               // The bus address must stay put until the stale read returns.
               squash_pc_next = fetch_pc_reg;
               fetch_pc_next  = redirect_pc;
               state_next     = SQUASH;
            end else if (i_mem_resp) begin
               enq           = 1'b1;
               fetch_pc_next = fetch_pc_reg + width'(PC_STEP);
               // This push fills the ring only if it was one short and nothing leaves.
               if (count == CNT_W'(depth - 1) && !deq_fire) begin
                  state_next = IDLE;
               end else begin
                  state_next = FETCH;
               end
            end
         end
         SQUASH: begin
            if (redirect) begin
               fetch_pc_next = redirect_pc;
            end
            if (i_mem_resp) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign i_mem_read    = (state_reg != IDLE);
   assign i_mem_address = (state_reg == SQUASH) ? squash_pc_reg : fetch_pc_reg;

   fetch_buffer #(
      .width (width),
      .depth (depth)
   ) u_buffer (
      .clk        (clk),
      .rst        (rst),
      .clear      (redirect),
      .enq        (enq),
      .enq_pc     (fetch_pc_reg),
      .enq_instr  (i_mem_rdata),
      .deq        (deq),
      .head_pc    (out_pc),
      .head_instr (out_instr),
      .count      (count),
      .empty      (empty),
      .full       (full)
   );

   assign out_valid = ~empty;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios plus a randomised run, with
// a memory responder and a queue-based reference model of the fetch stream.
module tb_fetch_queue;
   import rv32i_types::*;

   localparam int          DEPTH  = 8;
   localparam logic [31:0] RST_PC = 32'h0000_0060;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_mem_resp;
   logic [31:0] i_mem_rdata;
   logic        i_mem_read;
   logic [31:0] i_mem_address;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        deq;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        empty;
   logic        full;
   logic [3:0]  count;

   always #5 clk = ~clk;

   fetch_queue #(
      .width    (32),
      .depth    (DEPTH),
      .RESET_PC (RST_PC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_mem_resp    (i_mem_resp),
      .i_mem_rdata   (i_mem_rdata),
      .i_mem_read    (i_mem_read),
      .i_mem_address (i_mem_address),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .deq           (deq),
      .out_valid     (out_valid),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .empty         (empty),
      .full          (full),
      .count         (count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: the queue contents and the address the next read must use.
   fetch_entry_t model_q[$];
   logic [31:0]  next_pc;
   bit           busy;
   bit           kept;
   int           lat_left;
   logic [31:0]  req_addr;
   int           lat_lo = 1;
   int           lat_hi = 1;
   int           n_pops = 0;
   bit           have_last;
   logic [31:0]  last_pop_pc;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      int sz;
      sz = model_q.size();
      chk("count", 32'(count), 32'(sz));
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("full", 32'(full), 32'(sz == DEPTH));
      chk("out_valid", 32'(out_valid), 32'(sz != 0));
      chk("count_bound", 32'(count <= 4'd8), 32'd1);
      if (sz > 0) begin
         chk("out_pc", out_pc, model_q[0].pc);
         chk("out_instr", out_instr, model_q[0].instr);
      end
      if (busy) chk("read_held", 32'(i_mem_read), 32'd1);
      if (sz == DEPTH && !busy) chk("no_read_when_full", 32'(i_mem_read), 32'd0);
   endtask

   task automatic model_reset();
      model_q.delete();
      next_pc   = RST_PC;
      busy      = 1'b0;
      kept      = 1'b0;
      have_last = 1'b0;
   endtask

   // One clock cycle: drive inputs, answer memory, advance, update model, check.
   task automatic cyc(input bit rd, input logic [31:0] rpc, input bit dq);
      bit popped;
      logic [31:0] pop_pc;
      redirect    = rd;
      redirect_pc = rpc;
      deq         = dq;
      i_mem_resp  = 1'b0;
      i_mem_rdata = $urandom();
      popped      = dq && out_valid && !rd;
      pop_pc      = out_pc;
      if (i_mem_read && !busy) begin
         busy     = 1'b1;
         kept     = 1'b1;
         req_addr = i_mem_address;
         lat_left = $urandom_range(lat_hi, lat_lo);
         chk("req_addr", i_mem_address, next_pc);
      end
      if (busy) begin
         chk("addr_stable", i_mem_address, req_addr);
         lat_left--;
         if (lat_left == 0) begin
            i_mem_resp  = 1'b1;
            i_mem_rdata = word_at(req_addr);
         end
      end
      @(posedge clk);
      #1;
      if (rd) begin
         model_q.delete();
         next_pc   = rpc;
         kept      = 1'b0;
         have_last = 1'b0;
      end else begin
         if (dq && model_q.size() > 0) void'(model_q.pop_front());
         if (i_mem_resp && kept) begin
            model_q.push_back('{pc: req_addr, instr: word_at(req_addr)});
            next_pc = next_pc + 32'd4;
         end
      end
      if (popped) begin
         n_pops++;
         if (have_last) chk("pop_monotonic", pop_pc, last_pop_pc + 32'd4);
         have_last   = 1'b1;
         last_pop_pc = pop_pc;
      end
      if (i_mem_resp) begin
         $display("read addr=%h kept=%0d count=%0d", req_addr, kept, count);
         busy = 1'b0;
         kept = 1'b0;
      end
      redirect   = 1'b0;
      deq        = 1'b0;
      i_mem_resp = 1'b0;
      check_outputs();
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      redirect   = 1'b0;
      deq        = 1'b0;
      i_mem_resp = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      chk("rst_read", 32'(i_mem_read), 32'd0);
      check_outputs();
   endtask

   initial begin
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      deq         = 1'b0;
      i_mem_resp  = 1'b0;
      i_mem_rdata = '0;
      model_reset();

      // Reset, then 1-cycle memory: first entry visible one cycle after resp.
      do_reset();
      lat_lo = 1; lat_hi = 1;
      cyc(0, '0, 0);
      chk("first_read", 32'(i_mem_read), 32'd1);
      chk("first_addr", i_mem_address, RST_PC);
      cyc(0, '0, 0);
      chk("first_valid", 32'(out_valid), 32'd1);
      chk("first_pc", out_pc, RST_PC);
      chk("first_instr", out_instr, word_at(RST_PC));

      // No deq: fill to depth, reads stop; one deq restarts at 0x80.
      for (int k = 0; k < 30 && !full; k++) cyc(0, '0, 0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd8);
      chk("fill_noread", 32'(i_mem_read), 32'd0);
      chk("fill_head", out_pc, RST_PC);
      cyc(0, '0, 0);
      chk("full_stays_idle", 32'(i_mem_read), 32'd0);
      cyc(0, '0, 1);
      cyc(0, '0, 0);
      chk("refill_read", 32'(i_mem_read), 32'd1);
      chk("refill_addr", i_mem_address, 32'h0000_0080);

      // Redirect during a 3-cycle read at 0x64: squash holds 0x64 until resp.
      do_reset();
      lat_lo = 3; lat_hi = 3;
      for (int k = 0; k < 20 && !(busy && req_addr == 32'h64); k++) cyc(0, '0, 0);
      chk("sq_setup_addr", i_mem_address, 32'h0000_0064);
      cyc(1, 32'h0000_0200, 0);
      chk("sq_read", 32'(i_mem_read), 32'd1);
      chk("sq_addr", i_mem_address, 32'h0000_0064);
      chk("sq_empty", 32'(empty), 32'd1);
      cyc(0, '0, 0);
      chk("sq_resp_idle", 32'(i_mem_read), 32'd0);
      chk("sq_discard", 32'(count), 32'd0);
      cyc(0, '0, 0);
      chk("sq_new_read", 32'(i_mem_read), 32'd1);
      chk("sq_new_addr", i_mem_address, 32'h0000_0200);

      // Redirect coincident with resp and deq at count=3.
      do_reset();
      lat_lo = 1; lat_hi = 1;
      for (int k = 0; k < 20 && count != 4'd3; k++) cyc(0, '0, 0);
      chk("co_count3", 32'(count), 32'd3);
      cyc(1, 32'h0000_0300, 1);
      chk("co_count0", 32'(count), 32'd0);
      chk("co_idle", 32'(i_mem_read), 32'd0);
      cyc(0, '0, 0);
      chk("co_addr", i_mem_address, 32'h0000_0300);

      // Randomised traffic with occasional redirects.
      do_reset();
      lat_lo = 1; lat_hi = 3;
      n_pops = 0;
      for (int k = 0; k < 4000 && n_pops < 200; k++) begin
         cyc(($urandom_range(0, 199) == 0), 32'($urandom_range(0, 1023)) << 2,
             ($urandom_range(0, 99) < 45));
      end
      chk("rand_wraps", 32'(n_pops >= 160), 32'd1);

      // Reset mid-read with hostile simultaneous inputs, then a late resp.
      lat_lo = 3; lat_hi = 3;
      for (int k = 0; k < 10 && !busy; k++) cyc(0, '0, 0);
      chk("mid_busy", 32'(i_mem_read), 32'd1);
      rst         = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0400;
      deq         = 1'b1;
      i_mem_resp  = 1'b1;
      i_mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      rst = 1'b0; redirect = 1'b0; deq = 1'b0; i_mem_resp = 1'b0;
      model_reset();
      chk("mid_rst_read", 32'(i_mem_read), 32'd0);
      check_outputs();
      i_mem_resp  = 1'b1;
      i_mem_rdata = 32'hBAD0_BAD0;
      @(posedge clk);
      #1;
      i_mem_resp = 1'b0;
      chk("late_resp_count", 32'(count), 32'd0);
      chk("restart_read", 32'(i_mem_read), 32'd1);
      chk("restart_addr", i_mem_address, RST_PC);
      for (int k = 0; k < 12; k++) cyc(0, '0, 0);
      chk("restart_head", out_pc, RST_PC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
